// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential double-dabble BCD converter:
// FSM state encodings, add-3 rule constants, default widths and the
// iteration-counter width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    localparam int BIN_W_DEF  = 13;
    localparam int DIGITS_DEF = 4;

    // Bits needed to count 0..w-1, never less than one.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
// The result never exceeds 4 bits for a legal BCD input (max 9+3 = 12).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Conditional add-3; no carry out is needed.
    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a start/done
// handshake. One shift per cycle; digit outputs are updated atomically on
// the DONE edge so the downstream display driver never sees partial data.
// Optional macro BCD_AUTO_START_EN: also launch a conversion whenever the
// binary input differs from the last converted value.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
)
(
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_Start,
    input  logic [BIN_W-1:0] i_Binary,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [3:0]       o_Thousands,
    output logic [3:0]       o_Hundreds,
    output logic [3:0]       o_Tens,
    output logic [3:0]       o_Ones
);

    localparam int SCR_W = DIGITS * 4;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t                   state_reg, state_next;
    logic [BIN_W-1:0]         shift_reg, shift_next;
    logic [SCR_W-1:0]         scratch_reg, scratch_next;
    logic [SCR_W-1:0]         adjusted;
    logic [SCR_W+BIN_W-1:0]   shifted;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;
    logic [SCR_W-1:0]         result_reg, result_next;
    logic                     start;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch_reg[gi*4 +: 4]),
                .adjusted (adjusted[gi*4 +: 4])
            );
        end
    endgenerate

`ifdef BCD_AUTO_START_EN
    logic [BIN_W-1:0] last_reg;

    // Remember the value taken by the most recent accepted conversion.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            last_reg <= '1;
        end else if (state_reg == ST_IDLE && start) begin
            last_reg <= i_Binary;
        end
    end

    assign start = i_Start | (i_Binary != last_reg);
`else
    assign start = i_Start;
`endif

    // Adjusted scratch concatenated with the binary bits, shifted left once;
    // the bit leaving the top digit is dropped.
    assign shifted = {adjusted, shift_reg} << 1;

    // State and datapath register update.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            scratch_reg <= scratch_next;
            count_reg   <= count_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            result_reg  <= result_next;
        end
    end

    // Next-state and next-datapath logic for IDLE -> SHIFT x BIN_W -> DONE.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        scratch_next = scratch_reg;
        count_next   = count_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        result_next  = result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next   = i_Binary;
                    scratch_next = '0;
                    count_next   = '0;
                    busy_next    = 1'b1;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_next = shifted[SCR_W+BIN_W-1 -: SCR_W];
                shift_next   = shifted[BIN_W-1:0];
                count_next   = count_reg + 1'b1;
                if (count_reg == CNT_W'(BIN_W - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                result_next = scratch_reg;
                done_next   = 1'b1;
                busy_next   = 1'b0;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_Busy      = busy_reg;
    assign o_Done      = done_reg;
    assign o_Thousands = result_reg[15:12];
    assign o_Hundreds  = result_reg[11:8];
    assign o_Tens      = result_reg[7:4];
    assign o_Ones      = result_reg[3:0];

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq. Expected digits come from
// decimal division of the value; timing expectations from the handshake
// rules (done BIN_W+1 edges after acceptance, BIN_W+2 cycles per
// back-to-back conversion). Build with BCD_AUTO_START_EN to run the
// auto-launch scenario instead of the start-driven one.
module tb_bcd_convert_seq;
    import bcd_pkg::*;

    localparam int BW = BIN_W_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] bin = '1;
    logic          busy, done;
    logic [3:0]    th, hu, te, on;

    int            checks = 0;
    int            failures = 0;
    logic [15:0]   shown = '0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.BIN_W(BW), .DIGITS(DIGITS_DEF)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_Start     (start),
        .i_Binary    (bin),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Thousands (th),
        .o_Hundreds  (hu),
        .o_Tens      (te),
        .o_Ones      (on)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] digits();
        return {th, hu, te, on};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_digits", digits(), 0);
        shown = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Idle stretch: no done, not busy, digits unchanged.
    task automatic quiet(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            check({tag, "_nodone"}, done, 0);
            check({tag, "_idle"}, busy, 0);
            check({tag, "_held"}, digits(), shown);
        end
    endtask

    // One conversion; poke = extra start + input change mid-flight,
    // scramble = random input change after acceptance.
    task automatic run_conv(input int v, input bit poke, input bit scramble);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        bin = BW'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        if (scramble) bin = BW'($urandom_range(0, (1 << BW) - 1));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 5) begin
                start = 1'b1;
                bin = BW'(7);
            end
            if (poke && n == 6) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("hold_digits", digits(), shown);
                check("busy_during", busy, 1);
            end
        end
        check("latency", n, BW + 1);
        check("result", digits(), to_bcd(v));
        check("busy_end", busy, 0);
        shown = to_bcd(v);
        $display("conv value=%0d digits=%0h latency=%0d", v, digits(), n);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
    endtask

`ifdef BCD_AUTO_START_EN
    task automatic auto_tests();
        int n;
        int cnt;
        do_reset();
        quiet(5, "auto_q0");
        @(negedge clk);
        bin = BW'(42);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("auto_latency", n, BW + 2);
        check("auto_result", digits(), to_bcd(42));
        shown = to_bcd(42);
        $display("auto value=42 digits=%0h", digits());
        quiet(40, "auto_hold");
        @(negedge clk);
        bin = BW'(43);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        check("auto_one_done", cnt, 1);
        check("auto_result43", digits(), to_bcd(43));
        $display("auto value=43 digits=%0h dones=%0d", digits(), cnt);
    endtask
`endif

    initial begin
        int k;
        int cyc;
        int last;
        int v;
`ifdef BCD_AUTO_START_EN
        auto_tests();
`else
        do_reset();
        quiet(3, "q0");
        run_conv(0, 1'b0, 1'b0);
        run_conv(8191, 1'b0, 1'b0);
        run_conv(1234, 1'b0, 1'b0);
        run_conv(9, 1'b0, 1'b0);
        run_conv(4095, 1'b1, 1'b0);
        quiet(20, "ignore");

        // Reset in the middle of a conversion of 5000.
        @(negedge clk);
        start = 1'b1;
        bin = BW'(5000);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("abort_nodone", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_digits", digits(), 0);
        shown = '0;
        $display("abort digits=%0h busy=%0d", digits(), busy);
        @(negedge clk);
        rst = 1'b0;
        quiet(20, "abort_q");
        run_conv(5000, 1'b0, 1'b0);

        // Start held high, input stepping 0..20.
        @(negedge clk);
        start = 1'b1;
        bin = '0;
        k = 0;
        cyc = 0;
        last = -1;
        while (k <= 20 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                check("b2b_result", digits(), to_bcd(k));
                if (last >= 0) check("b2b_period", cyc - last, BW + 2);
                $display("b2b value=%0d digits=%0h cycle=%0d", k, digits(), cyc);
                last = cyc;
                k++;
                if (k <= 20) bin = BW'(k);
                else start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", k, 21);
        shown = to_bcd(20);
        quiet(20, "b2b_q");

        // Random values with the input disturbed after acceptance.
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, (1 << BW) - 1));
            run_conv(v, 1'b0, 1'b1);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
